vx_writeback_arbiter: RTL and testbench

Producer of the writeback-stage bus that the forwarding unit and register file consume. It merges the execute-side result stream with the memory-response stream into one registered writeback record per cycle. It buffers memory responses in a small FIFO and arbitrates with ALU priority plus an optional starvation guard. It sits between the execute/memory stages and the writeback stage; its outputs drive `in_writeback_*` of forwarding and the register-file write port.

---
 rtl/vx_writeback_arbiter_pkg.sv | 45 ++++
 rtl/vx_wb_resp_fifo.sv | 65 ++++++
 rtl/vx_writeback_arbiter.sv | 167 ++++++++++++++++
 tb/tb_vx_writeback_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_writeback_arbiter_pkg.sv
// Shared writeback codes, thread/warp geometry, arbiter state and record layouts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vx_writeback_arbiter_pkg;

    localparam int NT = 4;   // threads per warp (data lanes)
    localparam int NW = 2;   // warp id width

    localparam logic [1:0] NO_WB  = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;
    localparam logic [1:0] WB_JAL = 2'd3;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef enum logic [0:0] {
        ALU_PRI   = 1'b0,
        MEM_DRAIN = 1'b1
    } arb_state_e;

    // Memory response as stored in the response FIFO.
    typedef struct packed {
        logic [4:0]       dest;
        logic [NW-1:0]    warp_num;
        logic [NT-1:0]    thread_mask;
        logic [NT*32-1:0] data;
    } mem_rec_t;

    // Registered writeback record driven onto the writeback bus.
    typedef struct packed {
        logic             valid;
        logic [4:0]       dest;
        logic [1:0]       wb;
        logic [NT*32-1:0] data;
        logic [31:0]      pc_next;
        logic [NW-1:0]    warp_num;
        logic [NT-1:0]    thread_mask;
    } wb_rec_t;

    // Replicate one 32-bit value into every thread lane.
    function automatic logic [NT*32-1:0] lane_bcast(input logic [31:0] v);
        return {NT{v}};
    endfunction

endpackage

// File: rtl/vx_wb_resp_fifo.sv
// Synchronous FIFO holding memory responses for the writeback arbiter.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: full_o stays high until a pop completes; pushes while full are dropped internally.
module vx_wb_resp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards every queued entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/vx_writeback_arbiter.sv
// Merges ALU results and buffered memory responses into one registered writeback record per cycle.
// Latency: ALU input to out_wb_* 1 cycle; memory response (always via FIFO) at least 2 cycles.
// Backpressure: in_mem_ready=!full; out_alu_stall during forced drain (only with WB_STARVE_GUARD_EN).
module vx_writeback_arbiter
    import vx_writeback_arbiter_pkg::*;
#(
    parameter int MEM_BUF_DEPTH = 4,
    parameter int STARVE_MAX    = 8
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             in_alu_valid,
    input  logic [4:0]       in_alu_dest,
    input  logic [1:0]       in_alu_wb,
    input  logic [NT*32-1:0] in_alu_result,
    input  logic [31:0]      in_alu_PC_next,
    input  logic [NW-1:0]    in_alu_warp_num,
    input  logic [NT-1:0]    in_alu_thread_mask,

    input  logic             in_mem_valid,
    output logic             in_mem_ready,
    input  logic [4:0]       in_mem_dest,
    input  logic [NW-1:0]    in_mem_warp_num,
    input  logic [NT-1:0]    in_mem_thread_mask,
    input  logic [NT*32-1:0] in_mem_data,

    output logic             out_alu_stall,

    output logic             out_wb_valid,
    output logic [4:0]       out_wb_dest,
    output logic [1:0]       out_wb_wb,
    output logic [NT*32-1:0] out_wb_data,
    output logic [31:0]      out_wb_PC_next,
    output logic [NW-1:0]    out_wb_warp_num,
    output logic [NT-1:0]    out_wb_thread_mask
);

    // Reject geometries the FIFO pointer wrap and the starve counter cannot support.
    if ((MEM_BUF_DEPTH < 2) || ((MEM_BUF_DEPTH & (MEM_BUF_DEPTH - 1)) != 0) || (STARVE_MAX < 1)) begin : g_bad_cfg
        $error("vx_writeback_arbiter: MEM_BUF_DEPTH must be a power of two >= 2, STARVE_MAX >= 1");
    end

    mem_rec_t push_rec;
    mem_rec_t head_rec;
    logic     fifo_full, fifo_empty;
    logic     mem_push;
    logic     alu_win, mem_win;
    logic     drain;
    wb_rec_t  wb_q, wb_d;

    assign push_rec = '{dest:        in_mem_dest,
                        warp_num:    in_mem_warp_num,
                        thread_mask: in_mem_thread_mask,
                        data:        in_mem_data};

    // Held low during reset so a response presented then is never taken.
    assign in_mem_ready = !fifo_full && !reset;
    assign mem_push     = in_mem_valid && in_mem_ready;

    vx_wb_resp_fifo #(
        .WIDTH ($bits(mem_rec_t)),
        .DEPTH (MEM_BUF_DEPTH)
    ) u_resp_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (mem_push),
        .push_dat_i (push_rec),
        .pop_i      (mem_win),
        .head_dat_o (head_rec),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    // Arbiter state and starve counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ALU_PRI;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Count ALU wins that leave a response waiting; force one memory pop at the limit.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (mem_win || fifo_empty) begin
            starve_d = '0;
        end else if (alu_win && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
        end
        case (state_q)
            ALU_PRI:   if (starve_d == STARVE_LIM) state_d = MEM_DRAIN;
            MEM_DRAIN: if (mem_win || fifo_empty) state_d = ALU_PRI;
            default:   state_d = ALU_PRI;
        endcase
    end

    assign drain = (state_q == MEM_DRAIN);
`else
    assign drain = 1'b0;
`endif

    assign out_alu_stall = drain;

    // Pick at most one source: forced drain first, then ALU, then the FIFO head.
    always_comb begin
        alu_win = 1'b0;
        mem_win = 1'b0;
        if (drain) begin
            mem_win = !fifo_empty;
        end else if (in_alu_valid) begin
            alu_win = 1'b1;
        end else begin
            mem_win = !fifo_empty;
        end
    end

    // Build the next record; payload fields hold when nothing wins.
    always_comb begin
        wb_d       = wb_q;
        wb_d.valid = 1'b0;
        wb_d.wb    = NO_WB;
        if (alu_win) begin
            wb_d.valid       = 1'b1;
            wb_d.dest        = in_alu_dest;
            wb_d.wb          = (in_alu_dest == ZERO_REG) ? NO_WB : in_alu_wb;
            wb_d.data        = (in_alu_wb == WB_JAL) ? lane_bcast(in_alu_PC_next) : in_alu_result;
            wb_d.pc_next     = in_alu_PC_next;
            wb_d.warp_num    = in_alu_warp_num;
            wb_d.thread_mask = in_alu_thread_mask;
        end else if (mem_win) begin
            wb_d.valid       = 1'b1;
            wb_d.dest        = head_rec.dest;
            wb_d.wb          = (head_rec.dest == ZERO_REG) ? NO_WB : WB_MEM;
            wb_d.data        = head_rec.data;
            wb_d.pc_next     = '0;
            wb_d.warp_num    = head_rec.warp_num;
            wb_d.thread_mask = head_rec.thread_mask;
        end
    end

    // Output record register; all-zero reset also encodes out_wb_wb = NO_WB.
    always_ff @(posedge clk) begin
        if (reset) wb_q <= '0;
        else       wb_q <= wb_d;
    end

    assign out_wb_valid       = wb_q.valid;
    assign out_wb_dest        = wb_q.dest;
    assign out_wb_wb          = wb_q.wb;
    assign out_wb_data        = wb_q.data;
    assign out_wb_PC_next     = wb_q.pc_next;
    assign out_wb_warp_num    = wb_q.warp_num;
    assign out_wb_thread_mask = wb_q.thread_mask;

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// Bench for vx_writeback_arbiter: directed vectors, queue-based reference model, per-cycle compare.
// Latency: model predicts each cycle's registered record from the previous cycle's inputs.
// Backpressure: model FIFO occupancy predicts in_mem_ready and the starvation stall.
module tb_vx_writeback_arbiter;

    localparam int DEPTH  = 4;
    localparam int STARVE = 8;
    localparam logic [1:0] E_NO  = 2'd0;
    localparam logic [1:0] E_ALU = 2'd1;
    localparam logic [1:0] E_MEM = 2'd2;
    localparam logic [1:0] E_JAL = 2'd3;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_alu_valid;
    logic [4:0]   in_alu_dest;
    logic [1:0]   in_alu_wb;
    logic [127:0] in_alu_result;
    logic [31:0]  in_alu_PC_next;
    logic [1:0]   in_alu_warp_num;
    logic [3:0]   in_alu_thread_mask;
    logic         in_mem_valid;
    logic         in_mem_ready;
    logic [4:0]   in_mem_dest;
    logic [1:0]   in_mem_warp_num;
    logic [3:0]   in_mem_thread_mask;
    logic [127:0] in_mem_data;
    logic         out_alu_stall;
    logic         out_wb_valid;
    logic [4:0]   out_wb_dest;
    logic [1:0]   out_wb_wb;
    logic [127:0] out_wb_data;
    logic [31:0]  out_wb_PC_next;
    logic [1:0]   out_wb_warp_num;
    logic [3:0]   out_wb_thread_mask;

    vx_writeback_arbiter #(.MEM_BUF_DEPTH(DEPTH), .STARVE_MAX(STARVE)) dut (
        .clk(clk), .reset(reset),
        .in_alu_valid(in_alu_valid), .in_alu_dest(in_alu_dest), .in_alu_wb(in_alu_wb),
        .in_alu_result(in_alu_result), .in_alu_PC_next(in_alu_PC_next),
        .in_alu_warp_num(in_alu_warp_num), .in_alu_thread_mask(in_alu_thread_mask),
        .in_mem_valid(in_mem_valid), .in_mem_ready(in_mem_ready), .in_mem_dest(in_mem_dest),
        .in_mem_warp_num(in_mem_warp_num), .in_mem_thread_mask(in_mem_thread_mask),
        .in_mem_data(in_mem_data), .out_alu_stall(out_alu_stall),
        .out_wb_valid(out_wb_valid), .out_wb_dest(out_wb_dest), .out_wb_wb(out_wb_wb),
        .out_wb_data(out_wb_data), .out_wb_PC_next(out_wb_PC_next),
        .out_wb_warp_num(out_wb_warp_num), .out_wb_thread_mask(out_wb_thread_mask)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]   dest;
        logic [1:0]   warp;
        logic [3:0]   mask;
        logic [127:0] data;
    } mrec_t;

    mrec_t        mq[$];
    int           streak = 0;      // ALU wins in a row with a response waiting
    bit           model_live = 1'b0;
    logic         e_valid;
    logic [1:0]   e_wb;
    logic [4:0]   e_dest;
    logic [127:0] e_data;
    logic [31:0]  e_pc;
    logic [1:0]   e_warp;
    logic [3:0]   e_mask;

    always @(posedge clk) begin : model
        int    qn;
        bit    owed, take_alu, take_mem;
        mrec_t h;
        if (reset) begin
            mq.delete();
            streak = 0;
            e_valid = 1'b0; e_wb = E_NO; e_dest = '0; e_data = '0;
            e_pc = '0; e_warp = '0; e_mask = '0;
            model_live = 1'b1;
        end else begin
            qn       = mq.size();
            owed     = GUARD && (streak >= STARVE);
            take_alu = !owed && in_alu_valid;
            take_mem = !take_alu && (qn > 0);
            if (take_alu) begin
                e_valid = 1'b1;
                e_dest  = in_alu_dest;
                e_wb    = (in_alu_dest == 5'd0) ? E_NO : in_alu_wb;
                e_data  = (in_alu_wb == E_JAL) ? {4{in_alu_PC_next}} : in_alu_result;
                e_pc    = in_alu_PC_next;
                e_warp  = in_alu_warp_num;
                e_mask  = in_alu_thread_mask;
            end else if (take_mem) begin
                h = mq.pop_front();
                e_valid = 1'b1;
                e_dest  = h.dest;
                e_wb    = (h.dest == 5'd0) ? E_NO : E_MEM;
                e_data  = h.data;
                e_pc    = '0;
                e_warp  = h.warp;
                e_mask  = h.mask;
            end else begin
                e_valid = 1'b0;
                e_wb    = E_NO;
            end
            if (take_mem || qn == 0) streak = 0;
            else if (take_alu)       streak++;
            // Room is judged on pre-edge occupancy: a same-cycle pop frees nothing.
            if (in_mem_valid && qn < DEPTH) begin
                h.dest = in_mem_dest; h.warp = in_mem_warp_num;
                h.mask = in_mem_thread_mask; h.data = in_mem_data;
                mq.push_back(h);
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (model_live) begin
            chk("wb_valid", 128'(out_wb_valid), 128'(e_valid));
            chk("wb_wb", 128'(out_wb_wb), 128'(e_wb));
            chk("wb_dest", 128'(out_wb_dest), 128'(e_dest));
            chk("wb_data", out_wb_data, e_data);
            chk("wb_pc_next", 128'(out_wb_PC_next), 128'(e_pc));
            chk("wb_warp", 128'(out_wb_warp_num), 128'(e_warp));
            chk("wb_mask", 128'(out_wb_thread_mask), 128'(e_mask));
            chk("mem_ready", 128'(in_mem_ready), 128'(!reset && (mq.size() < DEPTH)));
            chk("alu_stall", 128'(out_alu_stall), 128'(GUARD && (streak >= STARVE)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [1:0] wb, input logic [4:0] d,
                             input logic [127:0] r, input logic [31:0] pc);
        in_alu_valid = v; in_alu_wb = wb; in_alu_dest = d;
        in_alu_result = r; in_alu_PC_next = pc;
        in_alu_warp_num = d[1:0]; in_alu_thread_mask = d[3:0] | 4'h1;
    endtask

    task automatic drive_mem(input logic v, input logic [4:0] d, input logic [127:0] dat);
        in_mem_valid = v; in_mem_dest = d; in_mem_data = dat;
        in_mem_warp_num = ~d[1:0]; in_mem_thread_mask = d[4:1];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive_alu(0, E_NO, 5'd0, '0, '0);
        drive_mem(0, 5'd0, '0);
        repeat (3) cyc();
        chk("rst_valid", 128'(out_wb_valid), 128'(0));
        chk("rst_wb", 128'(out_wb_wb), 128'(E_NO));
        chk("rst_data", out_wb_data, 128'(0));
        chk("rst_ready_low", 128'(in_mem_ready), 128'(0));
        chk("rst_stall", 128'(out_alu_stall), 128'(0));
        reset = 1'b0;
        cyc();
        chk("post_rst_ready", 128'(in_mem_ready), 128'(1));

        // Plain ALU result.
        drive_alu(1, E_ALU, 5'd5, {4{32'h11}}, 32'h104);
        cyc();
        chk("alu_valid", 128'(out_wb_valid), 128'(1));
        chk("alu_wb", 128'(out_wb_wb), 128'(E_ALU));
        chk("alu_dest", 128'(out_wb_dest), 128'(5));
        chk("alu_data", out_wb_data, {4{32'h11}});

        // JAL: PC_next replicated across lanes.
        drive_alu(1, E_JAL, 5'd1, {4{32'hDEADBEEF}}, 32'h80000010);
        cyc();
        chk("jal_wb", 128'(out_wb_wb), 128'(E_JAL));
        chk("jal_data", out_wb_data, {4{32'h80000010}});

        // Idle: no record, payload holds.
        drive_alu(0, E_ALU, 5'd9, '0, '0);
        cyc();
        chk("idle_valid", 128'(out_wb_valid), 128'(0));
        chk("idle_wb", 128'(out_wb_wb), 128'(E_NO));
        chk("idle_dest_hold", 128'(out_wb_dest), 128'(1));

        // Write to the zero register is emitted without a write.
        drive_alu(1, E_ALU, 5'd0, {4{32'h22}}, 32'h200);
        cyc();
        chk("zero_valid", 128'(out_wb_valid), 128'(1));
        chk("zero_wb", 128'(out_wb_wb), 128'(E_NO));

        // Memory response with ALU idle: visible two cycles after the push.
        drive_alu(0, E_NO, 5'd0, '0, '0);
        drive_mem(1, 5'd7, {32'h703, 32'h702, 32'h701, 32'h700});
        cyc();
        drive_mem(0, 5'd0, '0);
        chk("mem_not_yet", 128'(out_wb_valid), 128'(0));
        chk("mem_ready_n1", 128'(in_mem_ready), 128'(1));
        cyc();
        chk("mem_wb", 128'(out_wb_wb), 128'(E_MEM));
        chk("mem_dest", 128'(out_wb_dest), 128'(7));
        chk("mem_data", out_wb_data, {32'h703, 32'h702, 32'h701, 32'h700});
        chk("mem_pc_zero", 128'(out_wb_PC_next), 128'(0));
        chk("mem_ready_n2", 128'(in_mem_ready), 128'(1));

        // Continuous ALU with one waiting response.
        drive_alu(1, E_ALU, 5'd3, 128'(100), 32'h300);
        drive_mem(1, 5'd8, {4{32'h88}});
        cyc();
        drive_mem(0, 5'd0, '0);
        for (int k = 1; k <= 8; k++) begin
            drive_alu(1, E_ALU, 5'd3, 128'(100 + k), 32'h300);
            cyc();
        end
        chk("starve_stall", 128'(out_alu_stall), 128'(GUARD));
        cyc();
        chk("starve_rec", 128'(out_wb_wb), 128'(GUARD ? E_MEM : E_ALU));
        chk("starve_stall_off", 128'(out_alu_stall), 128'(0));
        cyc();
        chk("starve_resume", 128'(out_wb_wb), 128'(E_ALU));
        drive_alu(0, E_NO, 5'd0, '0, '0);
        repeat (3) cyc();

        // Fill the FIFO behind continuous ALU traffic.
        drive_alu(1, E_ALU, 5'd4, {4{32'h44}}, 32'h400);
        for (int k = 0; k < 4; k++) begin
            drive_mem(1, 5'(16 + k), {4{32'(16 + k)}});
            cyc();
        end
        chk("bp_ready_full", 128'(in_mem_ready), 128'(0));
        drive_mem(1, 5'd20, {4{32'h20}});
        cyc();
        chk("bp_ready_held", 128'(in_mem_ready), 128'(0));
        cyc();
        drive_alu(0, E_NO, 5'd0, '0, '0);
        cyc();
        chk("bp_first_drain", 128'(out_wb_wb), 128'(E_MEM));
        chk("bp_first_dest", 128'(out_wb_dest), 128'(16));
        chk("bp_ready_back", 128'(in_mem_ready), 128'(1));
        cyc();
        drive_mem(0, 5'd0, '0);
        repeat (6) cyc();

        // Reset with three entries queued and a response presented during reset.
        drive_alu(1, E_ALU, 5'd6, {4{32'h66}}, 32'h600);
        for (int k = 0; k < 3; k++) begin
            drive_mem(1, 5'(21 + k), {4{32'(21 + k)}});
            cyc();
        end
        reset = 1'b1;
        drive_mem(1, 5'd24, {4{32'h24}});
        cyc();
        chk("midrst_ready", 128'(in_mem_ready), 128'(0));
        chk("midrst_valid", 128'(out_wb_valid), 128'(0));
        cyc();
        reset = 1'b0;
        drive_mem(0, 5'd0, '0);
        drive_alu(0, E_NO, 5'd0, '0, '0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("midrst_no_mem", 128'(out_wb_wb), 128'(E_NO));
        end

        // Mixed traffic: concurrent pushes/pops, JAL, NO_WB and dest 0.
        for (int i = 0; i < 60; i++) begin
            drive_alu((i % 3) != 0,
                      (i % 5 == 0) ? E_NO : ((i % 4 == 1) ? E_JAL : E_ALU),
                      5'(i),
                      {32'(i + 3), 32'(i + 2), 32'(i + 1), 32'(i) ^ 32'hA5A5_0000},
                      32'h1000 + 32'(4 * i));
            drive_mem((i % 2) == 0, 5'(31 - (i % 32)), {4{32'(i * 7)}});
            cyc();
        end
        drive_alu(0, E_NO, 5'd0, '0, '0);
        drive_mem(0, 5'd0, '0);
        repeat (8) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
